imem_loader: RTL

- Writer side of the instruction-fetch path: streams a program image into instruction memory before the pipeline fetches from it.
- Words arrive over a valid/ready stream in this order: length word, data words, checksum word.
- Holds the pipeline in reset-equivalent stall (cpu_hold) until a verified image is in place.
- Sits between the bench/host stream source and the write port of the I_FETCH instruction memory.

---
 rtl/imem_loader.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: streams a program image (length, data words, XOR checksum)
// from a valid/ready source into the instruction memory write port, and
// holds the pipeline stalled until a verified image is in place.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   start           - single-cycle load request (honoured in IDLE/DONE/ERR)
//   in_valid/in_data/in_ready - input word stream (transfer on valid & ready)
//   imem_we/imem_addr/imem_wdata - instruction memory write port
//   cpu_hold        - 1 while the pipeline must not fetch
//   done / error    - verified-load / failed-load status levels
module imem_loader #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    // Remaining-word counter needs one extra bit so it can hold DEPTH itself.
    localparam int unsigned REM_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic                in_ready_q, in_ready_d;
    logic [ADDR_W-1:0]   addr_cnt_q, addr_cnt_d;
    logic [REM_W-1:0]    rem_q, rem_d;
    logic [31:0]         chk_q, chk_d;
    logic                imem_we_q, imem_we_d;
    logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
    logic [31:0]         imem_wdata_q, imem_wdata_d;
    logic                cpu_hold_q, cpu_hold_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                xfer;

    // A word moves only when the registered ready and the source's valid coincide.
    assign xfer = in_valid & in_ready_q;

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        addr_cnt_d   = addr_cnt_q;
        rem_d        = rem_q;
        chk_d        = chk_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        cpu_hold_d   = cpu_hold_q;
        done_d       = done_q;
        error_d      = error_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d    = S_LEN;
                    cpu_hold_d = 1'b1;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    addr_cnt_d = '0;
                end
            end
            S_LEN: begin
                if (xfer) begin
                    if ((in_data == 32'd0) || (in_data > 32'(DEPTH))) begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end else begin
                        state_d = S_DATA;
                        rem_d   = REM_W'(in_data);
                        chk_d   = '0;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = addr_cnt_q;
                    imem_wdata_d = in_data;
                    chk_d        = chk_q ^ in_data;
                    addr_cnt_d   = addr_cnt_q + ADDR_W'(1);
                    rem_d        = rem_q - REM_W'(1);
                    if (rem_q == REM_W'(1)) begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (xfer) begin
                    if (in_data == chk_q) begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Ready is registered from the state being entered, so it never depends on valid.
        in_ready_d = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CHECK);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            in_ready_q   <= 1'b0;
            addr_cnt_q   <= '0;
            rem_q        <= '0;
            chk_q        <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_hold_q   <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            addr_cnt_q   <= addr_cnt_d;
            rem_q        <= rem_d;
            chk_q        <= chk_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_hold_q   <= cpu_hold_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_hold   = cpu_hold_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule
